// File: rtl/md_pkg.sv
// Shared types and constants for the E-stage multiply/divide unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE,
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MTHI,
    MD_MTLO
  } md_op_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef logic [63:0] md_res_t;

  function automatic int md_cw(int m, int d);
    int mx;
    mx = (m > d) ? m : d;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/md_if.sv
// Decode strobes, operands and HI/LO results between E stage and md_unit.
interface md_if;
  logic        en;
  logic        mult;
  logic        multu;
  logic        div;
  logic        divu;
  logic        mthi;
  logic        mtlo;
  logic        mfhi;
  logic        mflo;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  modport master (
    output en, mult, multu, div, divu,
    output mthi, mtlo, mfhi, mflo, a, b,
    input  start, busy, hi, lo, rdata
  );

  modport slave (
    input  en, mult, multu, div, divu,
    input  mthi, mtlo, mfhi, mflo, a, b,
    output start, busy, hi, lo, rdata
  );
endinterface

// File: rtl/md_busy_counter.sv
// Down-counter modelling mult/div latency; done pulses on the 1->0 step.
module md_busy_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] init,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (load)
      cnt <= init;
    else if (busy)
      cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);
  assign done = (cnt == W'(1));

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, captures operands at start
// and commits the result when the busy counter expires.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);

  localparam int CW = md_cw(MULT_CYCLES, DIV_CYCLES);

  md_op_e      op;
  md_op_e      op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] dv;
  logic [CW-1:0] init;
  logic        start;
  logic        busy;
  logic        done;
  logic        wr;
  md_res_t     res;

  // Strobes only count for a valid, idle E stage; mult wins ties.
  always_comb begin
    op = MD_NONE;
    if (bus.en && !busy) begin
      priority case (1'b1)
        bus.mult:  op = MD_MULT;
        bus.multu: op = MD_MULTU;
        bus.div:   op = MD_DIV;
        bus.divu:  op = MD_DIVU;
        bus.mthi:  op = MD_MTHI;
        bus.mtlo:  op = MD_MTLO;
        default:   op = MD_NONE;
      endcase
    end
  end

  assign start = (op == MD_MULT) || (op == MD_MULTU) ||
                 (op == MD_DIV)  || (op == MD_DIVU);

  assign init = ((op == MD_MULT) || (op == MD_MULTU)) ?
                CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

  md_busy_counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .init  (init),
    .busy  (busy),
    .done  (done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= MD_NONE;
      a_q  <= '0;
      b_q  <= '0;
    end else if (start) begin
      op_q <= op;
      a_q  <= bus.a;
      b_q  <= bus.b;
    end
  end

  // Divisor forced nonzero so the datapath never produces X; wr blocks it.
  always_comb begin
    res = {hi_q, lo_q};
    wr  = 1'b0;
    dv  = (b_q == '0) ? 32'd1 : b_q;
    unique case (op_q)
      MD_MULT: begin
        res = $signed({{32{a_q[31]}}, a_q}) *
              $signed({{32{b_q[31]}}, b_q});
        wr  = 1'b1;
      end
      MD_MULTU: begin
        res = {32'd0, a_q} * {32'd0, b_q};
        wr  = 1'b1;
      end
      MD_DIV: begin
        if (a_q == 32'h8000_0000 && b_q == 32'hffff_ffff)
          res = {32'd0, 32'h8000_0000};
        else
          res = {$signed(a_q) % $signed(dv),
                 $signed(a_q) / $signed(dv)};
        wr  = (b_q != '0);
      end
      MD_DIVU: begin
        res = {a_q % dv, a_q / dv};
        wr  = (b_q != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done && wr) begin
      hi_q <= res[63:32];
      lo_q <= res[31:0];
    end else if (op == MD_MTHI) begin
      hi_q <= bus.a;
    end else if (op == MD_MTLO) begin
      lo_q <= bus.a;
    end
  end

  assign bus.start = start;
  assign bus.busy  = busy;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.rdata = bus.mfhi ? hi_q : lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Multiply/divide unit in the E stage of the pipelined MIPS core. It consumes the one-hot mult/multu/div/divu/mthi/mtlo/mfhi/mflo strobes from the R-type decode, carried down the pipeline registers. It owns the HI/LO registers and models multi-cycle latency with a busy counter. The D-stage stall logic uses start|busy to hold md-class instructions.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
en  in  1  E-stage instruction valid (0 on bubble/flush)
mult  in  1  signed multiply strobe
multu  in  1  unsigned multiply strobe
div  in  1  signed divide strobe
divu  in  1  unsigned divide strobe
mthi  in  1  write HI from a
mtlo  in  1  write LO from a
mfhi  in  1  select HI onto rdata
mflo  in  1  select LO onto rdata
a  in  32  rs operand (forwarded)
b  in  32  rt operand (forwarded)
start  out  1  combinational: en & ~busy & (mult|multu|div|divu)
busy  out  1  operation in flight
hi  out  32  HI register
lo  out  32  LO register
rdata  out  32  combinational: mfhi ? hi : lo

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, captured operands/op cleared. rdata=0 follows.
- Strobe priority if several are high (illegal, but defined): mult > multu > div > divu > mthi > mtlo.
- Start at cycle T (start=1):
  - a, b and the op are captured at edge T.
  - counter loads MULT_CYCLES or DIV_CYCLES.
  - Later changes on a/b have no effect.
- busy = (counter != 0). busy is high for exactly N cycles, T+1..T+N.
- Each edge with counter != 0 decrements the counter.
- At the edge where the counter goes 1->0, HI/LO receive the result and busy falls on the same edge. New hi/lo are visible in the first cycle with busy=0.
- Results:
  - mult: {hi,lo} = signed(a)*signed(b), 64-bit.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder, sign follows the dividend.
  - divu: unsigned quotient and remainder.
  - div with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b=0): full DIV_CYCLES busy period still runs; hi/lo unchanged at completion.
- While busy=1, all strobes are ignored: no start, and mthi/mtlo do not write. Upstream stalls guarantee this never happens.
- mthi/mtlo (en=1, busy=0, no start): hi (or lo) <= a at the next edge; latency 1.
- mfhi/mflo: pure combinational read of current registers. During busy, old values are returned; the stall contract prevents their use.
- en=0: no strobe has any effect. An in-flight operation continues regardless of en.
- Reset mid-operation: state is cleared immediately, and no late write occurs after reset releases.

Decomposition:
- Shared package md_pkg holds:
  - enum md_op_e: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - Constants MD_MULT_CYCLES=5 and MD_DIV_CYCLES=10.
  - 64-bit result typedef.
- One sub-module, md_busy_counter, owns load/decrement/busy/done-pulse. md_unit holds operand capture, arithmetic and HI/LO.

Test Plan:
- reset=0 for 2 cycles, then release -> hi=0, lo=0, busy=0, start=0 with en=0.
- mult a=0xFFFFFFFE, b=3 -> start=1 one cycle; busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFE, b=3 -> after 5 busy cycles hi=0x00000002, lo=0xFFFFFFFA. Changing a/b during busy leaves the result unchanged.
- div a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu a=7, b=0 -> busy for 10 cycles, hi/lo unchanged.
- mthi a=0x00001234 while idle -> hi=0x00001234 after 1 edge; rdata=0x00001234 with mfhi=1. Then mtlo a=0x5 and a second mult, both asserted during busy -> ignored, lo unchanged, no second busy period.
- Start div, pull reset low at busy cycle 4, release -> immediately busy=0, hi=lo=0; no HI/LO write in the following 10 cycles.
